bram_frame_reader: RTL and testbench
====================================

Name: bram_frame_reader

Overview:
- Read-side initiator for the sample-capture BRAM buffer.
- Waits until the capture side reports a full frame, then pulses a read request.
- Collects the burst of 2**ADDR_WIDTH words, which arrives at clock rate with no backpressure, into an internal frame FIFO.
- Re-streams the frame to the FFT input over a valid/ready handshake with first/last markers.

Parameters:
- WORD_WIDTH, 24, sample word width.
- ADDR_WIDTH, 3, log2 of words per frame (N = 2**ADDR_WIDTH).
- TIMEOUT, 64, max cycles in COLLECT between words (and from begin_read to first word) before abort.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  arms the reader; sampled in IDLE only.
- frame_ready  in  1  level, high while the capture buffer holds a complete frame.
- begin_read  out  1  single-cycle read request to capture side.
- rd_valid  in  1  rd_data carries a frame word this cycle.
- rd_data  in  WORD_WIDTH  burst word from capture buffer.
- m_data  out  WORD_WIDTH  stream word to FFT.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts when m_valid & m_ready.
- m_first  out  1  qualifies word index 0 of frame.
- m_last  out  1  qualifies word index N-1 of frame.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky; cleared only by reset.
- frames_done  out  8  count of fully streamed frames, wraps 255->0.

Behaviour:
- Reset (async, immediate): state=IDLE; FIFO emptied; word_cnt, out_cnt, timer = 0; begin_read=0, m_valid=0, m_first=0, m_last=0, busy=0, timeout_err=0, frames_done=0. Reset mid-burst discards partial frame; no output word appears after reset.
- IDLE: if enable & frame_ready & FIFO empty -> REQ. Otherwise stay.
- REQ: begin_read=1 for exactly this cycle -> COLLECT. word_cnt=0, timer=0.
- COLLECT:
  - Each cycle with rd_valid: push rd_data, word_cnt++, timer=0. Otherwise timer++.
  - When word N is pushed (word_cnt reaches N-1 with rd_valid) -> DRAIN.
  - If timer reaches TIMEOUT: set timeout_err, flush FIFO, out_cnt=0 -> IDLE. Any partial frame already streamed is not completed, and frames_done is not incremented.
- DRAIN: rd_valid is ignored (extra words are dropped). When the word with out_cnt==N-1 is accepted: frames_done++, out_cnt=0 -> WAIT_LOW.
- WAIT_LOW: stay until frame_ready==0 -> IDLE. This prevents re-reading the same frame.
- Output stream, independent of state:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - The word is popped on m_valid & m_ready; out_cnt increments on each pop.
  - m_first = m_valid & (out_cnt==0); m_last = m_valid & (out_cnt==N-1).
  - Streaming may overlap COLLECT. First-word latency: rd_valid at cycle t -> m_valid at t+1 (registered FIFO, no bypass).
  - m_data is held stable while m_valid & !m_ready.
- FIFO:
  - Depth N, so a whole frame fits even with m_ready held low.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
  - Push when full cannot occur, because REQ requires empty. If it does occur, the push is dropped.
- Widths:
  - word_cnt and out_cnt are ADDR_WIDTH+1 bits.
  - timer is clog2(TIMEOUT+1) bits and saturates at TIMEOUT.

Decomposition:
- Shared package: reader state encoding (IDLE, REQ, COLLECT, DRAIN, WAIT_LOW); FRAME_WORDS = 2**ADDR_WIDTH helper constant.
- One sub-module: frame_fifo. It is a synchronous register FIFO with parameters WORD_WIDTH and DEPTH_LOG2, ports push/pop/din/dout/empty/full, and async reset. Reset clears the pointers only; the storage array is not reset.

Test Plan:
- Nominal, N=8: enable=1, frame_ready=1 -> begin_read one cycle. Feed 8 contiguous rd_valid words 0x000001..0x000008 with m_ready=1. Expect m_data 1..8 in order, m_first on 0x000001, m_last on 0x000008, frames_done=1, state WAIT_LOW until frame_ready drops.
- Backpressure: m_ready=0 for the entire burst -> FIFO holds all 8 words, m_data stays 0x000001. Then m_ready=1 -> 8 words in consecutive cycles, no loss, m_last on the 8th.
- Gapped burst: rd_valid asserted every 3rd cycle with TIMEOUT=64 -> no timeout_err; output order correct.
- Timeout: begin_read issued, only 3 words delivered, then idle 64 cycles -> timeout_err=1, m_valid=0, state IDLE, frames_done unchanged. A following good frame streams correctly and timeout_err stays 1.
- Rearm: frame_ready held high after frame 1 -> no second begin_read. Drop for one cycle, raise again -> exactly one new begin_read, and frames_done reaches 2 after streaming.
- Async reset on the 5th word of a burst: all outputs go to 0 without a clock edge, FIFO is empty, and the next begin_read occurs only after a fresh enable & frame_ready.

Source files
------------

// File: rtl/bram_frame_reader_pkg.sv
// Shared definitions for the BRAM frame reader: FSM state encoding and frame-size helper.
package bram_frame_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_COLLECT,
        ST_DRAIN,
        ST_WAIT_LOW
    } reader_state_t;

    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int FRAME_WORDS        = 2 ** DEFAULT_ADDR_WIDTH;

    function automatic int frame_words(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage

// File: rtl/bram_frame_reader_fifo.sv
// Register FIFO holding one frame; pointers carry a wrap bit so full/empty need no counter.
module frame_fifo #(
    parameter int WORD_WIDTH = 24,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WORD_WIDTH-1:0] din,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately left out of reset; only pointers define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/bram_frame_reader.sv
// Requests a frame from the capture BRAM, buffers the burst and re-streams it to the FFT
// with first/last markers; aborts and flags a sticky error if the burst stalls.
module bram_frame_reader
    import bram_frame_reader_pkg::*;
#(
    parameter int WORD_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_ready,
    output logic                  begin_read,
    input  logic                  rd_valid,
    input  logic [WORD_WIDTH-1:0] rd_data,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [7:0]            frames_done
);
    localparam int N       = frame_words(ADDR_WIDTH);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH + 1)'(N - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = 1;
    localparam logic [TIMER_W-1:0]  TIMER_MAX = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0]  TIMER_LIM = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  TIMER_ONE = 1;

    reader_state_t       state, state_nxt;
    logic [ADDR_WIDTH:0] word_cnt;
    logic [ADDR_WIDTH:0] out_cnt;
    logic [TIMER_W-1:0]  timer;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                last_pop;
    logic                timeout_hit;

    assign push        = (state == ST_COLLECT) && rd_valid && !fifo_full;
    assign pop         = m_valid && m_ready;
    assign last_pop    = pop && (out_cnt == LAST_IDX);
    // Abort on the idle cycle that would bring the timer up to TIMEOUT.
    assign timeout_hit = (state == ST_COLLECT) && !rd_valid && (timer >= TIMER_LIM);

    assign begin_read = (state == ST_REQ);
    assign busy       = (state != ST_IDLE);
    assign m_valid    = !fifo_empty;
    assign m_first    = m_valid && (out_cnt == '0);
    assign m_last     = m_valid && (out_cnt == LAST_IDX);

    frame_fifo #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH_LOG2 (ADDR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (timeout_hit),
        .din   (rd_data),
        .dout  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (enable && frame_ready && fifo_empty) state_nxt = ST_REQ;
            ST_REQ:      state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (timeout_hit)                              state_nxt = ST_IDLE;
                else if (rd_valid && (word_cnt == LAST_IDX))  state_nxt = ST_DRAIN;
            end
            ST_DRAIN:    if (last_pop) state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!frame_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            out_cnt     <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
            frames_done <= 8'd0;
        end else begin
            state <= state_nxt;

            if (state == ST_REQ) begin
                word_cnt <= '0;
                timer    <= '0;
            end else if (state == ST_COLLECT) begin
                if (rd_valid) begin
                    word_cnt <= word_cnt + CNT_ONE;
                    timer    <= '0;
                end else if (timer != TIMER_MAX) begin
                    timer <= timer + TIMER_ONE;
                end
            end

            if (timeout_hit || last_pop) out_cnt <= '0;
            else if (pop)                out_cnt <= out_cnt + CNT_ONE;

            if (timeout_hit) timeout_err <= 1'b1;

            if (last_pop && (state == ST_DRAIN)) frames_done <= frames_done + 8'd1;
        end
    end

endmodule

// File: tb/tb_bram_frame_reader.sv
// Randomized bench for bram_frame_reader: a queue-based model predicts every output each cycle.
module tb_bram_frame_reader;
    localparam int W       = 24;
    localparam int AW      = 3;
    localparam int N       = 2 ** AW;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          frame_ready;
    logic          begin_read;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_first;
    logic          m_last;
    logic          busy;
    logic          timeout_err;
    logic [7:0]    frames_done;

    int checks   = 0;
    int failures = 0;

    bram_frame_reader #(.WORD_WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_ready(frame_ready),
        .begin_read(begin_read), .rd_valid(rd_valid), .rd_data(rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_first(m_first),
        .m_last(m_last), .busy(busy), .timeout_err(timeout_err), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 request, 2 collecting, 3 draining, 4 waiting for frame_ready low
    int           ph = 0;
    logic [W-1:0] mq[$];
    int           oidx = 0, got = 0, gap = 0, m_err = 0, m_frames = 0;
    logic [W+1:0] acc_q[$];
    int           br_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            ph = 0; mq.delete(); oidx = 0; got = 0; gap = 0; m_err = 0; m_frames = 0;
        end
        chk("begin_read", 32'(begin_read), 32'(ph == 1));
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("m_valid", 32'(m_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("m_data", 32'(m_data), 32'(mq[0]));
        chk("m_first", 32'(m_first), 32'(mq.size() > 0 && oidx == 0));
        chk("m_last", 32'(m_last), 32'(mq.size() > 0 && oidx == N - 1));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("frames_done", 32'(frames_done), 32'(m_frames % 256));
        if (begin_read) br_cnt++;
        if (m_valid && m_ready) acc_q.push_back({m_last, m_first, m_data});
        if (!reset) begin
            automatic int sz    = mq.size();
            automatic bit pop   = (sz > 0) && m_ready;
            automatic bit lastp = pop && (oidx == N - 1);
            automatic bit abort = 0;
            case (ph)
                0: if (enable && frame_ready && sz == 0) ph = 1;
                1: begin ph = 2; got = 0; gap = 0; end
                2: if (rd_valid) begin
                       if (sz < N) mq.push_back(rd_data);
                       got++; gap = 0;
                       if (got == N) ph = 3;
                   end else begin
                       gap++;
                       if (gap == TIMEOUT) begin abort = 1; ph = 0; m_err = 1; end
                   end
                3: if (lastp) begin m_frames++; ph = 4; end
                4: if (!frame_ready) ph = 0;
                default: ph = 0;
            endcase
            if (abort) begin
                mq.delete(); oidx = 0;
            end else if (pop) begin
                void'(mq.pop_front());
                oidx = lastp ? 0 : oidx + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic feed(input logic [W-1:0] d);
        rd_valid = 1'b1; rd_data = d; tick(); rd_valid = 1'b0;
    endtask

    task automatic wait_br();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (begin_read) begin ok = 1; break; end
            tick();
        end
        chk("begin_read_seen", 32'(ok), 32'd1);
        tick();
    endtask

    task automatic wait_frames(input int target);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (frames_done == 8'(target)) begin ok = 1; break; end
            tick();
        end
        chk("frames_done_reached", 32'(frames_done), 32'(target));
        if (!ok) $display("FAIL wait_frames: bound expired for target %0d", target);
    endtask

    task automatic rearm();
        frame_ready = 1'b0; tick(); tick(); frame_ready = 1'b1;
    endtask

    logic [W-1:0] bw [N];
    int           br_before;

    initial begin
        reset = 1'b1; enable = 1'b0; frame_ready = 1'b0;
        rd_valid = 1'b0; rd_data = '0; m_ready = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frames_done), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // Nominal frame, words 1..8
        enable = 1'b1; frame_ready = 1'b1; m_ready = 1'b1;
        acc_q.delete();
        wait_br();
        for (int i = 0; i < N; i++) feed(W'(i + 1));
        wait_frames(1);
        chk("nom_count", 32'(acc_q.size()), 32'(N));
        for (int i = 0; i < N && i < acc_q.size(); i++)
            chk("nom_word", 32'(acc_q[i]), 32'({(i == N - 1), (i == 0), W'(i + 1)}));
        for (int i = 0; i < 6; i++) tick();
        chk("waitlow_busy", 32'(busy), 32'd1);
        chk("no_reread", 32'(br_cnt), 32'd1);

        // Backpressure across the whole burst
        rearm();
        m_ready = 1'b0;
        wait_br();
        chk("rearm_one_req", 32'(br_cnt), 32'd2);
        for (int i = 0; i < N; i++) begin bw[i] = W'($urandom); feed(bw[i]); end
        for (int i = 0; i < 3; i++) tick();
        chk("bp_hold_valid", 32'(m_valid), 32'd1);
        chk("bp_hold_data", 32'(m_data), 32'(bw[0]));
        acc_q.delete();
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) tick();
        chk("bp_count", 32'(acc_q.size()), 32'(N));
        for (int i = 0; i < N && i < acc_q.size(); i++)
            chk("bp_word", 32'(acc_q[i]), 32'({(i == N - 1), (i == 0), bw[i]}));
        chk("bp_frames", 32'(frames_done), 32'd2);

        // Gapped burst, one word every third cycle
        rearm();
        wait_br();
        for (int i = 0; i < N; i++) begin feed(W'($urandom)); tick(); tick(); end
        wait_frames(3);
        chk("gap_no_timeout", 32'(timeout_err), 32'd0);

        // Timeout after three words
        rearm();
        m_ready = 1'b0;
        wait_br();
        for (int i = 0; i < 3; i++) feed(W'($urandom));
        for (int i = 0; i < TIMEOUT; i++) tick();
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_m_valid", 32'(m_valid), 32'd0);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_frames", 32'(frames_done), 32'd3);
        m_ready = 1'b1;
        wait_br();
        for (int i = 0; i < N; i++) feed(W'($urandom));
        wait_frames(4);
        chk("to_sticky", 32'(timeout_err), 32'd1);

        // Randomized frames with gaps, backpressure and stray words during drain
        for (int f = 0; f < 4; f++) begin
            rearm();
            wait_br();
            for (int k = 0; k < N; k++) begin
                automatic int g = $urandom_range(0, 4);
                for (int j = 0; j < g; j++) begin m_ready = 1'($urandom_range(0, 1)); tick(); end
                m_ready = 1'($urandom_range(0, 1));
                feed(W'($urandom));
            end
            for (int j = 0; j < 2; j++) begin
                m_ready = 1'($urandom_range(0, 1));
                rd_valid = 1'b1; rd_data = W'($urandom); tick();
            end
            rd_valid = 1'b0; m_ready = 1'b1;
            wait_frames(5 + f);
        end

        // Asynchronous reset on the fifth word of a burst
        rearm();
        wait_br();
        for (int i = 0; i < 4; i++) feed(W'($urandom));
        rd_valid = 1'b1; rd_data = W'($urandom);
        #2 reset = 1'b1;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_m_first", 32'(m_first), 32'd0);
        chk("arst_m_last", 32'(m_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_begin_read", 32'(begin_read), 32'd0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        chk("arst_frames", 32'(frames_done), 32'd0);
        rd_valid = 1'b0; enable = 1'b0;
        tick();
        reset = 1'b0;
        br_before = br_cnt;
        for (int i = 0; i < 10; i++) tick();
        chk("arst_no_req", 32'(br_cnt), 32'(br_before));
        enable = 1'b1;
        wait_br();
        for (int i = 0; i < N; i++) feed(W'($urandom));
        wait_frames(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
